// File: rtl/fifo_lane_pkg.sv
// -----------------------------------------------------------------------------
// fifo_lane_pkg
//   Shared types and defaults for the 1-to-N lane FIFO and its read-side
//   dispatcher (fifo_lane_dispatch).
//   - LANE_WIDTH / LANE_N_READERS : defaults shared with the lane FIFO
//   - dsp_state_e                 : dispatcher FSM state encoding
//   - occ_w(depth)                : width of an occupancy count for 'depth' entries
// -----------------------------------------------------------------------------
package fifo_lane_pkg;

  localparam int LANE_WIDTH     = 8;
  localparam int LANE_N_READERS = 2;

  typedef enum logic {
    DSP_RUN   = 1'b0,
    DSP_FLUSH = 1'b1
  } dsp_state_e;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lane_skid_fifo.sv
// -----------------------------------------------------------------------------
// lane_skid_fifo
//   Small per-reader skid buffer. Head entry is read combinationally from the
//   storage registers, so a pushed lane is visible on dout/valid the cycle
//   after the push.
// Ports
//   clk, rstn   clock, async active-low reset (clears storage and pointers)
//   clr         synchronous clear of pointers/occupancy (storage kept)
//   push, din   write din at the tail; ignored when full
//   pop         advance the head; ignored when empty
//   dout        head entry
//   valid       occupancy != 0
//   occ         current occupancy, 0..DEPTH
//   full        occupancy == DEPTH
// DEPTH must be a power of two (>=2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module lane_skid_fifo
  import fifo_lane_pkg::*;
#(
  parameter  int WIDTH = LANE_WIDTH,
  parameter  int DEPTH = 2,
  localparam int OCC_W = occ_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [OCC_W-1:0] occ,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ_q;
  logic             push_ok;
  logic             pop_ok;

  // Local guards keep occupancy inside 0..DEPTH even if a caller misbehaves.
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      occ_q <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      occ_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= din;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign valid = (occ_q != '0);
  assign full  = (occ_q == OCC_W'(DEPTH));
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_lane_dispatch.sv
// -----------------------------------------------------------------------------
// fifo_lane_dispatch
//   Read-side consumer of the 1-to-N lane FIFO. Turns per-reader same-cycle
//   lane grants into N independent valid/ready streams, with a skid buffer per
//   reader absorbing lanes while a sink stalls.
//
// Handshakes
//   Lane side : o_req[r] is a registered-only function (RUN, armed, buffer not
//               full). A lane is accepted when i_gnt[r] && o_req[r] in a cycle
//               without i_flush. i_gnt[r] while o_req[r]==0 (in RUN, no flush)
//               drops the lane and sets the sticky o_err.
//   Stream side: a beat transfers when o_valid[r] && i_ready[r] in a cycle
//               without i_flush. o_valid/o_data never depend on i_ready.
//
// Ports
//   i_rd_clk, i_rd_rstn  clock, async active-low reset
//   i_flush              sync flush of all buffers (wins over push/pop)
//   o_req  [N]           lane request per reader (FIFO read enables)
//   i_gnt  [N]           lane delivered for reader r this cycle
//   i_data [N*WIDTH]     lane data, slice r valid with i_gnt[r]
//   o_valid[N]           stream valid per reader
//   i_ready[N]           stream ready per reader
//   o_data [N*WIDTH]     head entry per reader
//   o_occ  [N*OCC_W]     buffer occupancy per reader
//   o_dbg_state          dispatcher FSM state (debug)
//   o_err                sticky protocol error
//   o_gnt_cnt [N*CNT_W]  per-reader saturating count of accepted lanes,
//                        present only when LANE_DISPATCH_STATS_EN is defined
// -----------------------------------------------------------------------------
module fifo_lane_dispatch
  import fifo_lane_pkg::*;
#(
  parameter  int WIDTH      = LANE_WIDTH,
  parameter  int N_READERS  = LANE_N_READERS,
  parameter  int SKID_DEPTH = 2,
  parameter  int CNT_W      = 16,
  localparam int OCC_W      = occ_w(SKID_DEPTH)
) (
  input  logic                       i_rd_clk,
  input  logic                       i_rd_rstn,
  input  logic                       i_flush,
  output logic [N_READERS-1:0]       o_req,
  input  logic [N_READERS-1:0]       i_gnt,
  input  logic [N_READERS*WIDTH-1:0] i_data,
  output logic [N_READERS-1:0]       o_valid,
  input  logic [N_READERS-1:0]       i_ready,
  output logic [N_READERS*WIDTH-1:0] o_data,
  output logic [N_READERS*OCC_W-1:0] o_occ,
  output dsp_state_e                 o_dbg_state,
  output logic                       o_err
`ifdef LANE_DISPATCH_STATS_EN
  ,
  output logic [N_READERS*CNT_W-1:0] o_gnt_cnt
`endif
);

  if (CNT_W < 1 || (1 << $clog2(SKID_DEPTH)) != SKID_DEPTH || SKID_DEPTH < 2) begin : g_param_check
    $error("fifo_lane_dispatch: SKID_DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  dsp_state_e           state;
  dsp_state_e           state_nxt;
  logic                 req_en;
  logic                 err_q;
  logic [N_READERS-1:0] full;
  logic [N_READERS-1:0] push;
  logic [N_READERS-1:0] pop;

  // ---------------------------------------------------------------------------
  // FSM: RUN <-> FLUSH, FLUSH held while i_flush stays high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      state  <= DSP_RUN;
      req_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      req_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DSP_RUN:   if (i_flush)  state_nxt = DSP_FLUSH;
      DSP_FLUSH: if (!i_flush) state_nxt = DSP_RUN;
      default:   state_nxt = DSP_RUN;
    endcase
  end

  assign o_dbg_state = state;

  // req_en keeps o_req low while reset is asserted; it is a register so o_req
  // stays free of any combinational input path.
  assign o_req = {N_READERS{(state == DSP_RUN) && req_en}} & ~full;

  // A flush in the same cycle discards both sides.
  assign push = i_gnt & o_req & {N_READERS{!i_flush}};
  assign pop  = o_valid & i_ready & {N_READERS{!i_flush}};

  // Grants are ignored while flushing; otherwise an unrequested grant is a
  // dropped lane.
  always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
    if (!i_rd_rstn) begin
      err_q <= 1'b0;
    end else if ((state == DSP_RUN) && !i_flush && |(i_gnt & ~o_req)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;

  // ---------------------------------------------------------------------------
  // Per-reader skid buffers
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < N_READERS; r++) begin : g_lane
    lane_skid_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (SKID_DEPTH)
    ) u_skid (
      .clk   (i_rd_clk),
      .rstn  (i_rd_rstn),
      .clr   (i_flush),
      .push  (push[r]),
      .din   (i_data[r*WIDTH +: WIDTH]),
      .pop   (pop[r]),
      .dout  (o_data[r*WIDTH +: WIDTH]),
      .valid (o_valid[r]),
      .occ   (o_occ[r*OCC_W +: OCC_W]),
      .full  (full[r])
    );
  end

`ifdef LANE_DISPATCH_STATS_EN
  for (genvar r = 0; r < N_READERS; r++) begin : g_stats
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
      if (!i_rd_rstn) begin
        cnt_q <= '0;
      end else if (i_flush) begin
        cnt_q <= '0;
      end else if (push[r] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign o_gnt_cnt[r*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
